stream_credit_tx: RTL and testbench
===================================

# stream_credit_tx

Credit-based transmit stage attached to one output port of the stream crossbar. Accepts a valid/ready stream (payload plus source index) and forwards it through a single register onto a link that has no back-pressure. Transfers are gated by a credit counter that mirrors the free buffer slots at the remote receiver. One instance sits on each crossbar output that drives an off-block or long-haul link.

## Interface
- `NumInp`, 32'd0: number of crossbar inputs; sizes the index field (`> 0`).
- `DataWidth`, 32'd1: payload width, used only by the default `payload_t`.
- `payload_t`, `logic [DataWidth-1:0]`: payload type.
- `NumCredits`, 32'd4: receiver buffer depth and counter reset value (`> 0`).
- `IdxWidth`, derived, do not override: `(NumInp > 1) ? $clog2(NumInp) : 1`.
- `idx_inp_t`, derived, do not override: `logic [IdxWidth-1:0]`.
- `CntWidth`, derived, do not override: `$clog2(NumCredits+1)`.

Ports:
- `clk_i`  in  1: clock, positive edge triggered.
- `rst_ni`  in  1: asynchronous reset, active low.
- `clr_i`  in  1: synchronous clear, active high.
- `data_i`  in  payload_t: input payload.
- `idx_i`  in  idx_inp_t: source index of the payload (from the crossbar `idx_o`).
- `valid_i`  in  1: input valid.
- `ready_o`  out  1: input ready.
- `data_o`  out  payload_t: link payload.
- `idx_o`  out  idx_inp_t: link source index.
- `valid_o`  out  1: link valid. Single-cycle pulse per transfer; there is no ready.
- `credit_i`  in  1: one-cycle pulse; the receiver freed one slot.
- `credit_cnt_o`  out  CntWidth: current credit count.
- `credit_err_o`  out  1: sticky credit overflow flag.

## Operation
- Credit counter `cnt_q`.
  - Resets to `NumCredits`.
  - `ready_o = (cnt_q != 0)`. It depends only on state, never on `valid_i`.
- Handshake `hs = valid_i & ready_o`.
- Counter update:
  - `hs & !credit_i`: decrement.
  - `!hs & credit_i`: increment.
  - Both set: unchanged.
  - Neither set: unchanged.
- Overflow:
  - Condition: `credit_i` while `cnt_q == NumCredits` and no `hs`.
  - The counter saturates at `NumCredits`.
  - This is an overflow event (see Configuration).
- Underflow is impossible by construction: no `hs` can occur at zero credits.
- Output register:
  - On `hs`: `valid_o <= 1`, `data_o <= data_i`, `idx_o <= idx_i`.
  - Otherwise `valid_o <= 0`; `data_o` and `idx_o` hold their previous values.
- `credit_cnt_o = cnt_q`.
- `clr_i` has priority over all other updates:
  - `cnt_q <= NumCredits`, `valid_o <= 0`, `credit_err_o <= 0`.
  - `ready_o` still follows `cnt_q` during the clear cycle; a handshake in that cycle is dropped.
  - The upstream side must not assert `valid_i` during `clr_i`.
- Payload arithmetic: none; payload and index pass through unmodified.

## Timing
- Latency: input handshake in cycle N gives `valid_o` in cycle N+1.
- Throughput: 1 transfer per cycle while credits remain. With `NumCredits` credits and no returns, exactly `NumCredits` back-to-back transfers are accepted, then `ready_o` drops in the cycle after the last handshake.
- A credit returned in cycle N raises `ready_o` in cycle N+1 (registered, no combinational path from `credit_i` to `ready_o`).
- Reset values:
  - `valid_o = 0`, `data_o = '0`, `idx_o = '0`.
  - `credit_cnt_o = NumCredits`, `ready_o = 1`, `credit_err_o = 0`.
- Asynchronous reset mid-operation discards the in-flight output beat. The receiver is reset in the same domain.
- AXI rules at the input: `ready_o` never depends on `valid_i`. Upstream must hold `valid_i`, `data_i` and `idx_i` stable until the handshake.

## Configuration
- Macro: `COMMON_CELLS_CREDIT_TX_ERR_EN`.
- Defined:
  - An overflow event sets `credit_err_o`, which stays set until `clr_i` or reset.
  - Simulation-only `$error` on overflow.
- Undefined:
  - `credit_err_o` is tied to `1'b0` and no error flop is synthesised.
  - Counter saturation behaviour is unchanged.

## Structure
- Package `cc_credit_pkg`:
  - Function `cnt_width(int unsigned n)` returning `$clog2(n+1)`.
  - Typedef of the output beat struct `{payload_t data; idx_inp_t idx;}`. It is parameter-dependent, so it is declared locally with the same field order.
- Sub-module `credit_counter`:
  - Parameters: `NumCredits`.
  - Ports: `clk_i`, `rst_ni`, `clr_i`, `consume_i`, `return_i`, `cnt_o`, `avail_o`, `ovf_o`.
  - Reused by the matching receive-side block.
- Assertions (translate_off, not under Verilator):
  - `NumInp > 0` and `NumCredits > 0`.
  - Input stability while `valid_i & !ready_o`.

## Test plan
- Reset release, `NumCredits=4`, `valid_i` held high with data 0x10..0x13, no credits returned -> four `valid_o` pulses in cycles 1..4 carrying 0x10..0x13; `ready_o=0` from cycle 4; `credit_cnt_o=0`.
- From zero credits, pulse `credit_i` once -> `credit_cnt_o=1` and `ready_o=1` next cycle; exactly one further beat accepted.
- `hs` and `credit_i` in the same cycle at `cnt=2` -> count stays 2; `valid_o` pulses.
- `credit_i` at `cnt=4` with no traffic -> count stays 4. With the macro defined, `credit_err_o=1` sticky until `clr_i`; without it, `credit_err_o` stays 0.
- `clr_i` asserted at `cnt=1` with `valid_o` pending -> next cycle `cnt=4`, `valid_o=0`, `credit_err_o=0`.
- Random `valid_i`/`credit_i` with a scoreboard model of a 4-entry receiver -> no receiver overflow, in-order `data_o`/`idx_o` match, and `cnt_q` always equals 4 minus outstanding beats.

Source files
------------

// File: rtl/cc_credit_pkg.sv
// Shared helpers for the credit-based link blocks (tx stage and matching rx side).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// The output beat struct depends on module parameters, so each user declares it
// locally as {payload_t data; idx_inp_t idx;}.
package cc_credit_pkg;

  // Width needed to hold values 0..n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return unsigned'($clog2(n + 1));
  endfunction

endpackage

// File: rtl/credit_counter.sv
// Credit counter mirroring the free slots at the remote receiver.
// Latency: consume/return update the count on the next clock edge.
// Backpressure: avail_o is purely registered state; consume while avail_o is low is not allowed.
//
// Ports: clk_i/rst_ni (async active-low), clr_i (sync clear to full),
//        consume_i (one credit used), return_i (one credit freed),
//        cnt_o (count), avail_o (count != 0), ovf_o (return at full count, no consume).
module credit_counter import cc_credit_pkg::*; #(
  parameter int unsigned NumCredits = 32'd4,
  parameter int unsigned CntWidth   = cnt_width(NumCredits)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clr_i,
  input  logic                consume_i,
  input  logic                return_i,
  output logic [CntWidth-1:0] cnt_o,
  output logic                avail_o,
  output logic                ovf_o
);

  localparam logic [CntWidth-1:0] CntMax = CntWidth'(NumCredits);
  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

  logic [CntWidth-1:0] cnt_q;
  logic                at_max;

  assign at_max  = (cnt_q == CntMax);
  assign cnt_o   = cnt_q;
  assign avail_o = (cnt_q != '0);
  // A simultaneous consume cancels the return, so that case is not an overflow.
  assign ovf_o   = return_i & ~consume_i & at_max;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= CntMax;
    end else if (clr_i) begin
      cnt_q <= CntMax;
    end else if (consume_i && !return_i && avail_o) begin
      cnt_q <= cnt_q - CntOne;
    end else if (return_i && !consume_i && !at_max) begin
      // Saturate: a surplus credit is reported via ovf_o, not counted.
      cnt_q <= cnt_q + CntOne;
    end
  end

endmodule

// File: rtl/stream_credit_tx.sv
// Credit-gated transmit stage: valid/ready stream in, registered no-backpressure link out.
// Latency: 1 cycle from input handshake to valid_o pulse.
// Backpressure: ready_o = credits available (registered, independent of valid_i); link has none.
//
// Ports: clk_i/rst_ni (async active-low), clr_i (sync clear),
//        data_i/idx_i/valid_i/ready_o (input stream),
//        data_o/idx_o/valid_o (link beat), credit_i (receiver freed a slot),
//        credit_cnt_o (current credits), credit_err_o (sticky overflow).
// Optional: define COMMON_CELLS_CREDIT_TX_ERR_EN to build the sticky overflow flag;
// otherwise credit_err_o is tied low.
module stream_credit_tx import cc_credit_pkg::*; #(
  parameter int unsigned NumInp     = 32'd0,
  parameter int unsigned DataWidth  = 32'd1,
  parameter type         payload_t  = logic [DataWidth-1:0],
  parameter int unsigned NumCredits = 32'd4,
  parameter int unsigned IdxWidth   = (NumInp > 32'd1) ? unsigned'($clog2(NumInp)) : 32'd1,
  parameter type         idx_inp_t  = logic [IdxWidth-1:0],
  parameter int unsigned CntWidth   = cnt_width(NumCredits)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clr_i,
  input  payload_t            data_i,
  input  idx_inp_t            idx_i,
  input  logic                valid_i,
  output logic                ready_o,
  output payload_t            data_o,
  output idx_inp_t            idx_o,
  output logic                valid_o,
  input  logic                credit_i,
  output logic [CntWidth-1:0] credit_cnt_o,
  output logic                credit_err_o
);

  typedef struct packed {
    payload_t data;
    idx_inp_t idx;
  } beat_t;

  logic  hs;
  logic  ovf;
  logic  valid_q;
  beat_t beat_q;

  assign hs = valid_i & ready_o;

  credit_counter #(
    .NumCredits (NumCredits),
    .CntWidth   (CntWidth)
  ) i_credit_counter (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (clr_i),
    .consume_i (hs),
    .return_i  (credit_i),
    .cnt_o     (credit_cnt_o),
    .avail_o   (ready_o),
    .ovf_o     (ovf)
  );

  // Payload/index only load on a handshake so the link sees stable data between beats.
  // A handshake during clr_i is dropped (clear wins); the counter is also reset then.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      beat_q  <= '0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= hs;
      if (hs) begin
        beat_q <= '{data: data_i, idx: idx_i};
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = beat_q.data;
  assign idx_o   = beat_q.idx;

`ifdef COMMON_CELLS_CREDIT_TX_ERR_EN
  logic err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (clr_i) begin
      err_q <= 1'b0;
    end else if (ovf) begin
      err_q <= 1'b1;
    end
  end

  assign credit_err_o = err_q;

`ifndef SYNTHESIS
  credit_overflow_check: assert property (
    @(posedge clk_i) disable iff (!rst_ni) !(ovf && !clr_i)
  ) else $error("stream_credit_tx: credit returned while counter already full");
`endif
`else
  logic unused_ovf;
  assign unused_ovf   = ovf;
  assign credit_err_o = 1'b0;
`endif

`ifndef SYNTHESIS
  if (NumInp == 0) begin : g_bad_numinp
    $error("stream_credit_tx: NumInp must be > 0");
  end
  if (NumCredits == 0) begin : g_bad_numcredits
    $error("stream_credit_tx: NumCredits must be > 0");
  end

  input_stable_check: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (valid_i && !ready_o) |=> (valid_i && $stable(data_i) && $stable(idx_i))
  ) else $error("stream_credit_tx: input changed while stalled");
`endif

endmodule

// File: tb/tb_stream_credit_tx.sv
module tb_stream_credit_tx;

  localparam int NCRED = 4;

`ifdef COMMON_CELLS_CREDIT_TX_ERR_EN
  localparam int ERR_EXP = 1;
`else
  localparam int ERR_EXP = 0;
`endif

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic [7:0] data_i;
  logic [1:0] idx_i;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] data_o;
  logic [1:0] idx_o;
  logic       valid_o;
  logic       credit_i;
  logic [2:0] credit_cnt_o;
  logic       credit_err_o;

  stream_credit_tx #(
    .NumInp     (4),
    .DataWidth  (8),
    .NumCredits (NCRED)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .clr_i        (clr),
    .data_i       (data_i),
    .idx_i        (idx_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .data_o       (data_o),
    .idx_o        (idx_o),
    .valid_o      (valid_o),
    .credit_i     (credit_i),
    .credit_cnt_o (credit_cnt_o),
    .credit_err_o (credit_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       vld;
    logic [7:0] dat;
    logic [1:0] idx;
    logic       crd;
    logic       clr;
    logic       e_rdy;
    logic       e_vld;
    logic [7:0] e_dat;
    logic [1:0] e_idx;
    logic [2:0] e_cnt;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_bad;

  task automatic add(input int vld, input int dat, input int idx, input int crd, input int cl,
                     input int e_rdy, input int e_vld, input int e_dat, input int e_idx,
                     input int e_cnt, input int e_err);
    vec_t r;
    r.vld   = 1'(vld);
    r.dat   = 8'(dat);
    r.idx   = 2'(idx);
    r.crd   = 1'(crd);
    r.clr   = 1'(cl);
    r.e_rdy = 1'(e_rdy);
    r.e_vld = 1'(e_vld);
    r.e_dat = 8'(e_dat);
    r.e_idx = 2'(e_idx);
    r.e_cnt = 3'(e_cnt);
    r.e_err = 1'(e_err);
    vecs.push_back(r);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_outputs(input string tag, input vec_t r);
    chk({tag, ".ready"}, int'(ready_o), int'(r.e_rdy));
    chk({tag, ".valid_o"}, int'(valid_o), int'(r.e_vld));
    chk({tag, ".data_o"}, int'(data_o), int'(r.e_dat));
    chk({tag, ".idx_o"}, int'(idx_o), int'(r.e_idx));
    chk({tag, ".cnt"}, int'(credit_cnt_o), int'(r.e_cnt));
    chk({tag, ".err"}, int'(credit_err_o), int'(r.e_err));
  endtask

  // Random-phase scoreboard state.
  logic [9:0] exp_q[$];  // beats accepted, awaiting appearance on link {idx,data}
  logic [9:0] rx_q[$];   // beats held in the modelled 4-entry receiver
  int         outs;      // beats sent whose receiver slot has not been credited back

  initial begin
    vec_t r;
    logic hs;
    logic [9:0] b;
    int   pend;
    logic [9:0] pend_beat;

    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    clr = 1'b0;
    valid_i = 1'b0;
    data_i = '0;
    idx_i = '0;
    credit_i = 1'b0;

    // vld dat idx crd clr | rdy vld dat idx cnt err
    add(1, 'h10, 0, 0, 0,  1, 1, 'h10, 0, 3, 0);
    add(1, 'h11, 1, 0, 0,  1, 1, 'h11, 1, 2, 0);
    add(1, 'h12, 2, 0, 0,  1, 1, 'h12, 2, 1, 0);
    add(1, 'h13, 3, 0, 0,  0, 1, 'h13, 3, 0, 0);
    add(1, 'h14, 0, 0, 0,  0, 0, 'h13, 3, 0, 0);  // stalled at zero credits
    add(1, 'h14, 0, 1, 0,  1, 0, 'h13, 3, 1, 0);  // credit returns, not yet ready
    add(1, 'h14, 0, 0, 0,  0, 1, 'h14, 0, 0, 0);  // exactly one more beat
    add(0, 'h00, 0, 1, 0,  1, 0, 'h14, 0, 1, 0);
    add(0, 'h00, 0, 1, 0,  1, 0, 'h14, 0, 2, 0);
    add(1, 'h20, 1, 1, 0,  1, 1, 'h20, 1, 2, 0);  // hs + credit at cnt=2
    add(0, 'h00, 0, 1, 0,  1, 0, 'h20, 1, 3, 0);
    add(0, 'h00, 0, 1, 0,  1, 0, 'h20, 1, 4, 0);
    add(0, 'h00, 0, 1, 0,  1, 0, 'h20, 1, 4, ERR_EXP);  // overflow, saturates
    add(0, 'h00, 0, 0, 0,  1, 0, 'h20, 1, 4, ERR_EXP);  // sticky
    add(1, 'h30, 2, 0, 0,  1, 1, 'h30, 2, 3, ERR_EXP);
    add(1, 'h31, 3, 0, 0,  1, 1, 'h31, 3, 2, ERR_EXP);
    add(1, 'h32, 0, 0, 0,  1, 1, 'h32, 0, 1, ERR_EXP);
    add(0, 'h00, 0, 0, 1,  1, 0, 'h32, 0, 4, 0);  // clear with beat pending
    add(0, 'h00, 0, 0, 0,  1, 0, 'h32, 0, 4, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    // Reset state.
    r.e_rdy = 1'b1; r.e_vld = 1'b0; r.e_dat = 8'h00; r.e_idx = 2'd0; r.e_cnt = 3'd4; r.e_err = 1'b0;
    n_vec++;
    chk_outputs("reset", r);

    foreach (vecs[i]) begin
      @(negedge clk);
      valid_i  = vecs[i].vld;
      data_i   = vecs[i].dat;
      idx_i    = vecs[i].idx;
      credit_i = vecs[i].crd;
      clr      = vecs[i].clr;
      @(posedge clk);
      #1;
      n_vec++;
      chk_outputs($sformatf("vec%0d", i), vecs[i]);
    end

    // Random traffic against a 4-entry receiver model.
    outs = 0;
    pend = 0;
    pend_beat = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      clr = 1'b0;
      credit_i = 1'b0;
      if (rx_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        void'(rx_q.pop_front());
        credit_i = 1'b1;
      end
      if (pend == 0 && cyc < 560 && $urandom_range(0, 9) < 7) begin
        pend = 1;
        pend_beat = 10'($urandom);
      end
      valid_i = (pend != 0);
      data_i  = pend_beat[7:0];
      idx_i   = pend_beat[9:8];
      #1;
      n_vec++;
      chk("rnd.ready", int'(ready_o), int'(outs < NCRED));
      chk("rnd.cnt", int'(credit_cnt_o), NCRED - outs);
      hs = valid_i && (outs < NCRED);
      if (hs) begin
        exp_q.push_back(pend_beat);
        pend = 0;
      end
      outs = outs + int'(hs) - int'(credit_i);
      @(posedge clk);
      #1;
      chk("rnd.valid_o", int'(valid_o), int'(hs));
      if (valid_o) begin
        if (exp_q.size() == 0) begin
          chk("rnd.unexpected_beat", 1, 0);
        end else begin
          b = exp_q.pop_front();
          chk("rnd.data_o", int'(data_o), int'(b[7:0]));
          chk("rnd.idx_o", int'(idx_o), int'(b[9:8]));
          rx_q.push_back(b);
          chk("rnd.rx_overflow", int'(rx_q.size() > NCRED), 0);
        end
      end
      if (cyc >= 560 && pend == 0 && rx_q.size() == 0 && exp_q.size() == 0) break;
    end
    valid_i = 1'b0;
    credit_i = 1'b0;
    n_vec++;
    chk("rnd.drained", int'(exp_q.size() + rx_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
